// File: rtl/rr_mux4_arbiter_pkg.sv
// rr_mux4_arbiter_pkg: shared types and constants for the round-robin 4:1 mux arbiter
package rr_mux4_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int HOLD_W  = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/rr_mux4_arbiter_pick.sv
// rr_pick4: combinational round-robin priority picker scanning ptr, ptr+1, ptr+2, ptr+3
module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);
    // scan from the farthest slot back to ptr so the nearest requester wins
    always_comb begin
        winner = '0;
        any    = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) winner = ptr + SEL_W'(i);
        end
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin owner of a shared 4:1 mux; ARB_HOLD_LIMIT_EN adds hold-limit preemption
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*DW-1:0]   in_data,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DW-1:0]     out_data,
    output logic              out_valid
);
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n, ptr, ptr_n, pick_ptr, winner;
    logic       ov_n, any, rel, pre;

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              others;
`endif

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    assign out_data = in_data[sel*DW +: DW];

    // next-state: grant from idle, keep while the owner requests, hand over on release or preemption
    always_comb begin
        rel      = (state == ST_OWN) && !req[sel];
`ifdef ARB_HOLD_LIMIT_EN
        others   = |(req & ~onehot(sel));
        pre      = (state == ST_OWN) && req[sel] && others && (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
        hold_n   = (state == ST_OWN && hold_cnt != '1) ? hold_cnt + 1'b1 : hold_cnt;
`else
        pre      = 1'b0;
`endif
        pick_ptr = (rel || pre) ? sel + 2'd1 : ptr;
        state_n  = state;
        gnt_n    = gnt;
        sel_n    = sel;
        ov_n     = out_valid;
        ptr_n    = ptr;
        if (state == ST_IDLE) begin
            if (any) begin
                state_n = ST_OWN;
                gnt_n   = onehot(winner);
                sel_n   = winner;
                ov_n    = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                hold_n  = '0;
`endif
            end
        end else if (rel || pre) begin
            ptr_n   = pick_ptr;
`ifdef ARB_HOLD_LIMIT_EN
            hold_n  = '0;
`endif
            if (any) begin
                gnt_n = onehot(winner);
                sel_n = winner;
            end else begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                ov_n    = 1'b0;
            end
        end
    end

    // state and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            out_valid <= ov_n;
            ptr       <= ptr_n;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= hold_n;
`endif
        end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed and random checks of rr_mux4_arbiter against a behavioural model
module tb_rr_mux4_arbiter;
    localparam int DW = 4;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] in_data = 16'hDCBA;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;

    int n_chk = 0;
    int n_fail = 0;
    int m_own = -1;
    int m_sel = 0;
    int m_ptr = 0;
    int m_hold = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_sel = 0;
        m_ptr = 0;
        m_hold = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int  w;
        bit  pre;
        if (m_own < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_own = w;
                m_sel = w;
                m_hold = 0;
            end
        end else begin
            pre = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            pre = r[m_own] && (m_hold >= MH - 1) && ((r & ~(4'b0001 << m_own)) != 4'b0000);
`endif
            if (!r[m_own] || pre) begin
                m_ptr = (m_own + 1) % 4;
                w = pick(r, m_ptr);
                m_own = w;
                m_hold = 0;
                if (w >= 0) m_sel = w;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("out_valid", 32'(out_valid), 32'(m_own >= 0));
        chk("out_data", 32'(out_data), 32'((in_data >> (4 * m_sel)) & 16'hF));
    endtask

    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        logic [3:0] r;
        #2;
        chk("por_gnt", 32'(gnt), 32'd0);
        chk("por_sel", 32'(sel), 32'd0);
        chk("por_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        cycle(4'b0000);
        chk("idle_gnt", 32'(gnt), 32'd0);
        cycle(4'b0101);
        chk("s1_gnt0", 32'(gnt), 32'b0001);
        chk("s1_sel0", 32'(sel), 32'd0);
        cycle(4'b0101);
        cycle(4'b0100);
        chk("s1_gnt2", 32'(gnt), 32'b0100);
        chk("s1_sel2", 32'(sel), 32'd2);
        chk("s1_nogap", 32'(out_valid), 32'd1);
        cycle(4'b0000);

        do_reset();
        r = 4'hF;
        cycle(r);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(sel), 32'(i % 4));
            chk("rr_lane", 32'(out_data), 32'(4'hA + 4'(i % 4)));
            cycle(r);
            r = 4'hF & ~(4'b0001 << (i % 4));
            cycle(r);
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1000);
            chk("p3_gnt", 32'(gnt), 32'b1000);
        end
        cycle(4'b0000);
        chk("p3_idle_gnt", 32'(gnt), 32'd0);
        chk("p3_idle_valid", 32'(out_valid), 32'd0);
        chk("p3_idle_sel", 32'(sel), 32'd3);
        cycle(4'b1001);
        chk("p3_wrap_gnt", 32'(gnt), 32'b0001);

        cycle(4'b0001);
        do_reset();
        cycle(4'b0010);
        chk("ar_gnt", 32'(gnt), 32'b0010);

        do_reset();
        cycle(4'b0110);
        chk("hl_first", 32'(gnt), 32'b0010);
        for (int c = 1; c <= 12; c++) begin
            cycle(4'b0110);
`ifdef ARB_HOLD_LIMIT_EN
            chk("hl_alt", 32'(sel), ((c / 4) % 2 == 1) ? 32'd2 : 32'd1);
`else
            chk("hl_hold", 32'(gnt), 32'b0010);
`endif
        end

        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            in_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
